// File: rtl/usb4_clk_pkg.sv
// Shared types, clock-ratio constants and phase-increment helper for the USB4 clock/reset sequencer.
package usb4_clk_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        GEN2 = 2'b01,
        GEN3 = 2'b10,
        GEN4 = 2'b11
    } gen_t;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_SWITCH = 2'd3
    } st_t;

    localparam int unsigned F_LOCAL_MHZ = 80000;
    localparam int unsigned F_SB_MHZ    = 1;

    // Reference increments for a 24-bit accumulator: round(f / 80 GHz * 2^24).
    localparam logic [63:0] INC24_GEN2_LANE = 64'd2097152;
    localparam logic [63:0] INC24_GEN2_FSM  = 64'd2033609;
    localparam logic [63:0] INC24_GEN3_LANE = 64'd4194304;
    localparam logic [63:0] INC24_GEN3_FSM  = 64'd4067217;
    localparam logic [63:0] INC24_GEN4_LANE = 64'd8388608;
    localparam logic [63:0] INC24_GEN4_FSM  = 64'd8388608;

    // Rescales the 24-bit reference increment to acc_w bits, rounding when narrowing.
    function automatic logic [63:0] inc_of(gen_t gen, bit fsm, int acc_w);
        logic [63:0] base;
        case (gen)
            GEN2:    base = fsm ? INC24_GEN2_FSM : INC24_GEN2_LANE;
            GEN3:    base = fsm ? INC24_GEN3_FSM : INC24_GEN3_LANE;
            GEN4:    base = fsm ? INC24_GEN4_FSM : INC24_GEN4_LANE;
            default: base = '0;
        endcase
        if (acc_w >= 24)
            return base << (acc_w - 24);
        else
            return (base + (64'd1 << (23 - acc_w))) >> (24 - acc_w);
    endfunction

endpackage

// File: rtl/phase_acc_strobe.sv
// Phase accumulator; strobe is the combinational carry of the pending add, registered by the parent.
module phase_acc_strobe #(
    parameter int unsigned ACC_W = 24
) (
    input  logic             local_clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] inc,
    input  logic             clr,
    input  logic             en,
    output logic             strobe
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum    = {1'b0, acc} + {1'b0, inc};
    assign strobe = en & sum[ACC_W];

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sum[ACC_W-1:0];
    end

endmodule

// File: rtl/usb4_clk_rst_gen.sv
// Clock-enable and reset sequencer for the USB4 logical layer: sideband tick, lane/FSM strobes,
// sequenced core reset and runtime generation switching, all on local_clk.
module usb4_clk_rst_gen
    import usb4_clk_pkg::*;
#(
    parameter int unsigned LANES    = 2,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned SB_DIV   = F_LOCAL_MHZ / F_SB_MHZ,
    parameter int unsigned RST_HOLD = 3
) (
    input  logic             local_clk,
    input  logic             rst,
    input  logic [1:0]       gen_sel,
    input  logic [LANES-1:0] lane_disable,
    input  logic             soft_rst_req,
    output logic             sb_tick,
    output logic [LANES-1:0] lane_en,
    output logic             fsm_en,
    output logic             core_rst_n,
    output logic [1:0]       gen_active,
    output logic             switch_done
);

    localparam int unsigned SB_W   = $clog2(SB_DIV);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [SB_W-1:0]   SB_LAST   = SB_W'(SB_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    st_t               st, nxt;
    logic [1:0]        rst_sync;
    logic [SB_W-1:0]   sb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              sw_cnt;
    logic [1:0]        sw_gen;
    logic [ACC_W-1:0]  lane_inc, fsm_inc;
    logic              acc_en, lane_stb, fsm_stb;

    assign lane_inc = ACC_W'(inc_of(gen_t'(gen_active), 1'b0, int'(ACC_W)));
    assign fsm_inc  = ACC_W'(inc_of(gen_t'(gen_active), 1'b1, int'(ACC_W)));

    // Accumulators only advance on cycles that stay in RUN, so leaving RUN never emits a strobe.
    assign acc_en = (st == ST_RUN) && (nxt == ST_RUN);

    always_comb begin
        nxt = st;
        case (st)
            ST_RESET:
                if (rst_sync[1]) nxt = ST_HOLD;
            ST_HOLD:
                if (sb_tick && hold_cnt == HOLD_LAST)
                    nxt = (gen_sel != gen_active) ? ST_SWITCH : ST_RUN;
            ST_RUN:
                if (soft_rst_req)                nxt = ST_HOLD;
                else if (gen_sel != gen_active)  nxt = ST_SWITCH;
            ST_SWITCH:
                if (soft_rst_req)                nxt = ST_HOLD;
                else if (gen_sel == sw_gen && sw_cnt) nxt = ST_RUN;
            default:
                nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            rst_sync    <= '0;
            st          <= ST_RESET;
            sb_cnt      <= '0;
            sb_tick     <= 1'b0;
            hold_cnt    <= '0;
            sw_cnt      <= 1'b0;
            sw_gen      <= '0;
            gen_active  <= '0;
            switch_done <= 1'b0;
            core_rst_n  <= 1'b0;
            lane_en     <= '0;
            fsm_en      <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            st       <= nxt;

            if (st == ST_RESET) begin
                sb_cnt  <= '0;
                sb_tick <= 1'b0;
            end else if (sb_cnt == SB_LAST) begin
                sb_cnt  <= '0;
                sb_tick <= 1'b1;
            end else begin
                sb_cnt  <= sb_cnt + 1'b1;
                sb_tick <= 1'b0;
            end

            if (nxt == ST_HOLD && st != ST_HOLD)
                hold_cnt <= '0;
            else if (st == ST_HOLD && sb_tick)
                hold_cnt <= hold_cnt + 1'b1;

            // A new target seen while switching restarts the two-cycle quiet period.
            if (nxt == ST_SWITCH && (st != ST_SWITCH || gen_sel != sw_gen)) begin
                sw_cnt <= 1'b0;
                sw_gen <= gen_sel;
            end else if (st == ST_SWITCH) begin
                sw_cnt <= 1'b1;
            end

            switch_done <= (st == ST_SWITCH) && (nxt == ST_RUN);
            if (st == ST_SWITCH && nxt == ST_RUN)
                gen_active <= sw_gen;

            core_rst_n <= (nxt == ST_RUN) || (nxt == ST_SWITCH);
            lane_en    <= {LANES{lane_stb}} & ~lane_disable;
            fsm_en     <= fsm_stb;
        end
    end

    phase_acc_strobe #(.ACC_W(ACC_W)) u_lane_acc (
        .local_clk (local_clk),
        .rst       (rst),
        .inc       (lane_inc),
        .clr       (!acc_en),
        .en        (acc_en),
        .strobe    (lane_stb)
    );

    phase_acc_strobe #(.ACC_W(ACC_W)) u_fsm_acc (
        .local_clk (local_clk),
        .rst       (rst),
        .inc       (fsm_inc),
        .clr       (!acc_en),
        .en        (acc_en),
        .strobe    (fsm_stb)
    );

endmodule

// File: doc/usb4_clk_rst_gen.md
# usb4_clk_rst_gen

Synthesizable clock-enable and reset sequencer for the USB4 logical layer. It runs entirely on `local_clk` (80 GHz nominal) and replaces free-running per-generation clocks with phase-accumulator strobes:
- a sideband tick;
- per-lane lane-rate enables for Gen2/Gen3/Gen4;
- the matching FSM-rate enable;
- a sequenced core reset.

It sits between the clock/reset pins and `logical_layer_no_scr`, and it adds runtime generation switching and per-lane gating.

## Interface
Parameters:
- `LANES`, 2: number of lane enables.
- `ACC_W`, 24: phase-accumulator width.
- `SB_DIV`, 80000: `local_clk` cycles per sideband tick (80 GHz / 1 MHz).
- `RST_HOLD`, 3: sideband ticks that `core_rst_n` is held low after reset release.

Ports:
- `local_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `gen_sel`  in  2  requested generation: 00 off, 01 Gen2, 10 Gen3, 11 Gen4.
- `lane_disable`  in  LANES  per-lane gate; 1 forces that lane's enable to 0.
- `soft_rst_req`  in  1  single-cycle request to re-run the reset hold.
- `sb_tick`  out  1  one-cycle pulse every `SB_DIV` cycles.
- `lane_en`  out  LANES  lane-rate strobes.
- `fsm_en`  out  1  FSM-rate strobe: 9.697 / 19.394 / 40 GHz equivalents.
- `core_rst_n`  out  1  sequenced active-low reset to the core.
- `gen_active`  out  2  generation currently driving the enables.
- `switch_done`  out  1  one-cycle pulse when a generation switch completes.

## Operation
- State machine `st`: RESET → HOLD → RUN; RUN ↔ SWITCH.
  - RESET: entered asynchronously on `rst`=0; leaves on the first clock after `rst` passes its 2-flop deassert synchronizer.
  - HOLD: `core_rst_n`=0; counts `sb_tick` pulses; after the `RST_HOLD`-th tick → RUN.
  - RUN: `core_rst_n`=1; enables active. `soft_rst_req`=1 → HOLD, with the hold counter cleared and accumulators cleared.
  - SWITCH: entered from RUN when `gen_sel` ≠ `gen_active`.
    - All enables are 0 and the accumulators are cleared for 2 cycles.
    - `gen_active` is then loaded with `gen_sel`, `switch_done` pulses, and the FSM returns to RUN.
    - `gen_sel` changes during SWITCH restart the 2-cycle count.
- Sideband counter: 0..`SB_DIV`-1. `sb_tick` is asserted when count = `SB_DIV`-1, then the counter wraps to 0. It runs in every state except RESET.
- Phase accumulators (`ACC_W` bits, one for lane and one for FSM) add an increment each RUN cycle. The carry out of the MSB is the strobe.
- Increments for `ACC_W`=24 are round(f / 80 GHz × 2^24):

  | Generation | Lane increment | FSM increment |
  |---|---|---|
  | Gen2 | 2097152 | 2033609 |
  | Gen3 | 4194304 | 4067217 |
  | Gen4 | 8388608 | 8388608 |

  For other `ACC_W` values the increments are scaled by a package function.
- `gen_active`=00: increments are 0, so there are no strobes.
- `lane_en[i]` = lane strobe & ~`lane_disable[i]`. `lane_disable` is sampled combinationally and its effect appears on the next registered output.
- Simultaneous events, in priority order:
  1. `rst`
  2. `soft_rst_req`
  3. `gen_sel` change
- If `gen_sel` differs from `gen_active` at HOLD exit, the FSM goes to SWITCH instead of RUN.

## Timing
- All outputs are registered. Reset values:
  - `sb_tick`=0
  - `lane_en`=0
  - `fsm_en`=0
  - `core_rst_n`=0
  - `gen_active`=00
  - `switch_done`=0
- Accumulators reset to 0.
- Strobe latency: the first RUN cycle loads acc = inc, and the strobe is registered on the cycle in which the accumulator wraps.
  - Gen4 lane: first `lane_en` on the 2nd RUN cycle, then every 2 cycles.
  - Gen3 lane: every 4 cycles.
  - Gen2 lane: every 8 cycles.
- FSM strobes for Gen2/Gen3 have an average period of 8.2500/4.1250 cycles, with jitter of ±1 cycle and no drift.
- Reset release: `rst` rising → 2 sync cycles → HOLD. `core_rst_n` rises 1 cycle after the `RST_HOLD`-th `sb_tick`.
- `rst` asserted mid-operation: all outputs drop to reset values immediately (asynchronously).

## Structure
- Package `usb4_clk_pkg`:
  - `gen_t` enum (OFF, GEN2, GEN3, GEN4);
  - `st_t` enum;
  - frequency constants;
  - function `inc_of(gen_t, bit fsm, int acc_w)`.
- Sub-module `phase_acc_strobe` (parameter `ACC_W`; ports `inc`, `clr`, `en`, `strobe`), instantiated twice.

## Test plan
1. `SB_DIV`=8, `RST_HOLD`=3, `gen_sel`=11 held:
   - release `rst` → `core_rst_n` rises 1 cycle after the 3rd `sb_tick`;
   - `lane_en`=11 on alternate cycles;
   - `fsm_en` matches `lane_en`.
2. Gen2 steady state, 8000 cycles → exactly 1000 `lane_en` pulses and 970 ± 1 `fsm_en` pulses.
3. Gen4→Gen3 switch in RUN:
   - exactly 2 cycles with no strobes;
   - then `gen_active`=10 and `switch_done` pulses once;
   - `lane_en` period becomes 4.
4. `lane_disable`=01 in Gen4 → `lane_en[0]` stays 0 and `lane_en[1]` keeps toggling; clearing it restores lane 0 within 1 strobe.
5. `soft_rst_req` and a `gen_sel` change in the same cycle → HOLD wins; `core_rst_n`=0 for 3 ticks; then SWITCH, then RUN.
6. `rst` asserted mid-strobe and mid-SWITCH → all outputs 0 in the same timestep; the sequence restarts from the synchronizer.
